audiosystem_track_ctrl: RTL
===========================

// Module: audiosystem_track_ctrl
// PURPOSE
//  Playback controller for the audio player: debounces the prev/next/play push-buttons and sequences track loading.
//  Holds the current track index and gates the audio datapath via play_en/load_req.
//  Exposes status, control and edge-capture registers to the Nios II on an Avalon-MM slave; raises an IRQ on button presses.
//  Sits between the board KEYs, the CPU bus and the audio sample reader.
// PARAMETERS
//  NUM_TRACKS  8        number of tracks; index wraps modulo NUM_TRACKS (>=2)
//  TRACK_W     3        width of track_idx; must satisfy 2**TRACK_W >= NUM_TRACKS
//  DEB_CYCLES  500000   cycles a synchronised button must be stable before it is accepted (10 ms @ 50 MHz)
//  POS_W       24       width of play_pos
//  RESTART_POS 44100    play_pos threshold used by the optional restart feature
// PORTS
//  clk         in   1        system clock
//  reset       in   1        synchronous, active-high reset
//  btn_prev_n  in   1        raw "previous" KEY, active-low, asynchronous
//  btn_next_n  in   1        raw "next" KEY, active-low, asynchronous
//  btn_play_n  in   1        raw play/pause KEY, active-low, asynchronous
//  address     in   2        Avalon-MM word address
//  write       in   1        Avalon write strobe
//  writedata   in   32       Avalon write data
//  readdata    out  32       Avalon read data, registered
//  irq         out  1        level interrupt to the CPU
//  track_idx   out  TRACK_W  current track
//  play_en     out  1        sample reader may stream
//  load_req    out  1        request to the reader to (re)load track_idx
//  load_ack    in   1        reader accepted the load
//  track_end   in   1        1-cycle pulse: current track has finished
//  play_pos    in   POS_W    samples played in the current track
// BEHAVIOUR
//  Reset values: state=STOPPED; track_idx=0, play_en=0, load_req=0, irq=0, readdata=0; ctrl=0; edge_cap=0.
//  Button path: 2-FF synchroniser -> debounce counter (count restarts on any change; the new level is accepted after DEB_CYCLES stable cycles) -> 1-cycle press pulse on each accepted falling edge of the raw input.
//  Button priority within one cycle: play > next > prev. Lower-priority presses are dropped for navigation but still set edge_cap.
//  Wrap: next at NUM_TRACKS-1 -> 0; prev at 0 -> NUM_TRACKS-1.
//  FSM:
//   STOPPED: play -> LOADING; next/prev -> adjust idx, remain STOPPED.
//   LOADING: load_req=1 until load_ack is sampled high -> PLAYING (load_req=0 from that cycle); buttons and track_end are ignored.
//   PLAYING: play_en=1.
//    play -> PAUSED.
//    next/prev -> adjust idx -> LOADING.
//    track_end -> idx+1 -> LOADING; at last track with ctrl.loop=0 -> idx=0 -> STOPPED.
//    A button press in the same cycle as track_end wins; track_end is discarded, so there is only one idx change.
//   PAUSED: play_en=0; play -> PLAYING; next/prev -> adjust idx -> LOADING.
//  play_en is 1 only in PLAYING and deasserts the cycle after the state is left.
//  Registers (writes take effect next cycle; readdata valid 1 cycle after address, read every cycle):
//   0 STATUS  RO {state[1:0] @ [9:8], track_idx @ [TRACK_W-1:0]}; encoding STOPPED=0, LOADING=1, PLAYING=2, PAUSED=3
//   1 CTRL    RW bit0 loop, bit1 irq_en
//   2 EDGECAP RW1C bits {play, next, prev} @ [2:0]; a new press in the same cycle as the clearing write keeps the bit set
//   3 TRACK   WO writedata[TRACK_W-1:0]; values >= NUM_TRACKS are ignored; in PLAYING/PAUSED also forces LOADING; also reads back idx
//  irq = irq_en & |edge_cap, registered.
//  Reset asserted mid-load drops load_req on the next edge; a later load_ack is ignored.
// CONFIGURATION
//  AUDIOSYSTEM_PREV_RESTART_EN defined:
//   In PLAYING/PAUSED, prev with play_pos >= RESTART_POS keeps idx and goes to LOADING (restart current track).
//   Otherwise prev behaves as normal.
//  Undefined: prev always decrements; play_pos is unused.
// STRUCTURE
//  Package audiosystem_track_pkg: state enum and encodings, register address constants, EDGECAP bit positions.
//  Sub-module audiosystem_debounce (synchroniser + counter + press pulse), instantiated three times.
// TESTING (bench: DEB_CYCLES=4, NUM_TRACKS=4)
//  Play held 2 cycles, or bouncing at 1-cycle intervals -> no press and EDGECAP=0; held 6 cycles -> one play press and EDGECAP=3'b100.
//  Play in STOPPED; load_ack 3 cycles later -> load_req high exactly until ack; STATUS = PLAYING, idx 0; play_en=1.
//  prev in STOPPED at idx 0 -> idx=3; next at idx 3 -> idx=0.
//  PLAYING idx 3, loop=0, track_end -> STOPPED, idx=0; loop=1 -> LOADING, idx=0.
//  next and track_end in the same cycle at idx 1 -> idx=2, one load_req.
//  irq_en=1, next press -> irq=1; write 3'b010 to EDGECAP -> irq=0 two cycles later.
//  TRACK write 5 -> ignored; write 2 while PAUSED -> LOADING, idx=2.
//  With macro: play_pos=50000 then prev at idx 2 -> idx stays 2, LOADING. Without macro -> idx=1.

Source files
------------

// File: rtl/audiosystem_track_pkg.sv
// rtl/audiosystem_track_pkg.sv - shared types and constants for the track controller
package audiosystem_track_pkg;

  // Playback states; encodings are visible in STATUS[9:8]
  typedef enum logic [1:0] {
    ST_STOPPED = 2'd0,
    ST_LOADING = 2'd1,
    ST_PLAYING = 2'd2,
    ST_PAUSED  = 2'd3
  } track_state_e;

  // Avalon-MM word addresses
  localparam logic [1:0] ADDR_STATUS  = 2'd0;
  localparam logic [1:0] ADDR_CTRL    = 2'd1;
  localparam logic [1:0] ADDR_EDGECAP = 2'd2;
  localparam logic [1:0] ADDR_TRACK   = 2'd3;

  // EDGECAP bit positions
  localparam int EDGE_PREV = 0;
  localparam int EDGE_NEXT = 1;
  localparam int EDGE_PLAY = 2;

  // CTRL bit positions
  localparam int CTRL_LOOP   = 0;
  localparam int CTRL_IRQ_EN = 1;

  // STATUS field position of the state code
  localparam int STATUS_STATE_LSB = 8;

endpackage

// File: rtl/audiosystem_debounce.sv
// rtl/audiosystem_debounce.sv - synchroniser, debounce counter and press pulse for one active-low key
module audiosystem_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_n,
  output logic press
);

  localparam int CNT_W = $clog2(DEB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             stable_q;
  logic [CNT_W-1:0] cnt_q;
  logic             press_q;

  // Two-flop synchroniser, then accept a new level once it has held DEB_CYCLES samples
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], btn_n};
      press_q <= 1'b0;
      if (sync_q[1] == stable_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        stable_q <= sync_q[1];
        cnt_q    <= '0;
        // Accepted level differs from a stable high, so this is a press
        press_q  <= stable_q;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign press = press_q;

endmodule

// File: rtl/audiosystem_track_ctrl.sv
// rtl/audiosystem_track_ctrl.sv - playback FSM, track index and Avalon-MM registers; option AUDIOSYSTEM_PREV_RESTART_EN
module audiosystem_track_ctrl
  import audiosystem_track_pkg::*;
#(
  parameter int NUM_TRACKS  = 8,
  parameter int TRACK_W     = 3,
  parameter int DEB_CYCLES  = 500000,
  parameter int POS_W       = 24,
  parameter int RESTART_POS = 44100
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_prev_n,
  input  logic               btn_next_n,
  input  logic               btn_play_n,
  input  logic [1:0]         address,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               irq,
  output logic [TRACK_W-1:0] track_idx,
  output logic               play_en,
  output logic               load_req,
  input  logic               load_ack,
  input  logic               track_end,
  input  logic [POS_W-1:0]   play_pos
);

  localparam logic [TRACK_W-1:0] IDX_LAST = TRACK_W'(NUM_TRACKS - 1);

  track_state_e       state_q, state_d;
  logic [TRACK_W-1:0] idx_q, idx_d;
  logic [TRACK_W-1:0] idx_inc, idx_dec;
  logic [1:0]         ctrl_q;
  logic [2:0]         edge_q, edge_d;
  logic               irq_q;
  logic [31:0]        rd_q, rd_d;
  logic               press_prev, press_next, press_play;
  logic               wr_ctrl, wr_edge, wr_track_ok;
  logic               restart;
  logic               unused_wdata;

  audiosystem_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_prev (
    .clk(clk), .reset(reset), .btn_n(btn_prev_n), .press(press_prev)
  );
  audiosystem_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_next (
    .clk(clk), .reset(reset), .btn_n(btn_next_n), .press(press_next)
  );
  audiosystem_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_play (
    .clk(clk), .reset(reset), .btn_n(btn_play_n), .press(press_play)
  );

  assign wr_ctrl     = write && (address == ADDR_CTRL);
  assign wr_edge     = write && (address == ADDR_EDGECAP);
  assign wr_track_ok = write && (address == ADDR_TRACK) && (writedata < 32'(NUM_TRACKS));
  assign unused_wdata = ^writedata[31:3];

  assign idx_inc = (idx_q == IDX_LAST) ? '0 : idx_q + TRACK_W'(1);
  assign idx_dec = (idx_q == '0) ? IDX_LAST : idx_q - TRACK_W'(1);

`ifdef AUDIOSYSTEM_PREV_RESTART_EN
  assign restart = (play_pos >= POS_W'(RESTART_POS));
`else
  logic unused_play_pos;
  assign restart = 1'b0;
  assign unused_play_pos = ^play_pos;
`endif

  // Next state and index: buttons (play > next > prev) beat track_end; a valid TRACK write overrides both
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      ST_STOPPED: begin
        if (press_play)      state_d = ST_LOADING;
        else if (press_next) idx_d = idx_inc;
        else if (press_prev) idx_d = idx_dec;
      end
      ST_LOADING: begin
        if (load_ack) state_d = ST_PLAYING;
      end
      ST_PLAYING, ST_PAUSED: begin
        if (press_play) begin
          state_d = (state_q == ST_PLAYING) ? ST_PAUSED : ST_PLAYING;
        end else if (press_next) begin
          idx_d   = idx_inc;
          state_d = ST_LOADING;
        end else if (press_prev) begin
          if (!restart) idx_d = idx_dec;
          state_d = ST_LOADING;
        end else if (track_end && (state_q == ST_PLAYING)) begin
          if ((idx_q == IDX_LAST) && !ctrl_q[CTRL_LOOP]) begin
            idx_d   = '0;
            state_d = ST_STOPPED;
          end else begin
            idx_d   = idx_inc;
            state_d = ST_LOADING;
          end
        end
      end
      default: state_d = ST_STOPPED;
    endcase
    if (wr_track_ok) begin
      idx_d = writedata[TRACK_W-1:0];
      if ((state_q == ST_PLAYING) || (state_q == ST_PAUSED)) state_d = ST_LOADING;
    end
  end

  // Edge capture: write-one-to-clear, but a press in the same cycle keeps its bit
  always_comb begin
    edge_d = edge_q;
    if (wr_edge) edge_d = edge_q & ~writedata[2:0];
    edge_d[EDGE_PLAY] = edge_d[EDGE_PLAY] | press_play;
    edge_d[EDGE_NEXT] = edge_d[EDGE_NEXT] | press_next;
    edge_d[EDGE_PREV] = edge_d[EDGE_PREV] | press_prev;
  end

  // Read mux, registered so readdata follows address by one cycle
  always_comb begin
    rd_d = '0;
    case (address)
      ADDR_STATUS: begin
        rd_d[STATUS_STATE_LSB +: 2] = state_q;
        rd_d[TRACK_W-1:0]           = idx_q;
      end
      ADDR_CTRL:    rd_d[1:0]         = ctrl_q;
      ADDR_EDGECAP: rd_d[2:0]         = edge_q;
      ADDR_TRACK:   rd_d[TRACK_W-1:0] = idx_q;
      default:      rd_d = '0;
    endcase
  end

  // State, index, registers and interrupt
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_STOPPED;
      idx_q   <= '0;
      ctrl_q  <= '0;
      edge_q  <= '0;
      irq_q   <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      edge_q  <= edge_d;
      rd_q    <= rd_d;
      irq_q   <= ctrl_q[CTRL_IRQ_EN] & (|edge_q);
      if (wr_ctrl) ctrl_q <= writedata[1:0];
    end
  end

  assign load_req  = (state_q == ST_LOADING);
  assign play_en   = (state_q == ST_PLAYING);
  assign track_idx = idx_q;
  assign irq       = irq_q;
  assign readdata  = rd_q;

endmodule
